// File: rtl/pipeline_interlock.sv
// Decode-stage hazard interlock for the MIPS pipeline.
// Covers the hazards the operand bypass cannot resolve: load-use against a load
// in ALU, dependencies on a load still outstanding in mem, and HI/LO access or
// new mult/div starts while the multiplier/divider is busy.
//
// state          | meaning
// ---------------+----------------------------------------------------------
// load_pending   | a load has left ALU and its data has not yet returned
// load_rd        | destination register of that outstanding load
// mdcnt == 0     | multiplier/divider idle, HI/LO results available
// mdcnt != 0     | multiplier/divider busy, counts down to the terminal count 0
module pipeline_interlock #(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 32,
  parameter int CNT_WIDTH    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       decode_valid,
  input  logic [4:0] decode_rs_index,
  input  logic [4:0] decode_rt_index,
  input  logic       decode_uses_rs,
  input  logic       decode_uses_rt,
  input  logic       decode_reads_hilo,
  input  logic       decode_muldiv_start,
  input  logic       decode_is_div,
  input  logic       alu_valid,
  input  logic       alu_is_load,
  input  logic [4:0] alu_rd_index,
  input  logic       mem_data_valid,
  output logic       stall,
  output logic       bubble,
  output logic       freeze,
  output logic       muldiv_start,
  output logic       muldiv_busy
);

  localparam logic [CNT_WIDTH-1:0] MULT_CNT = CNT_WIDTH'(MULT_LATENCY);
  localparam logic [CNT_WIDTH-1:0] DIV_CNT  = CNT_WIDTH'(DIV_LATENCY);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 load_pending;
  logic [4:0]           load_rd;
  logic [CNT_WIDTH-1:0] mdcnt;

  logic dep_alu;
  logic dep_mem;
  logic load_use;
  logic mem_dep;
  logic hilo_haz;

  // Source-operand match against the ALU-stage and outstanding-load destinations.
  // Register 0 is hardwired, so a zero index never creates a hazard.
  always_comb begin
    dep_alu = (alu_rd_index != 5'd0) &&
              ((decode_uses_rs && (decode_rs_index == alu_rd_index)) ||
               (decode_uses_rt && (decode_rt_index == alu_rd_index)));
    dep_mem = (load_rd != 5'd0) &&
              ((decode_uses_rs && (decode_rs_index == load_rd)) ||
               (decode_uses_rt && (decode_rt_index == load_rd)));
  end

  // Hazard terms and pipeline controls, all combinational from inputs and state.
  always_comb begin
    muldiv_busy  = (mdcnt != '0);
    load_use     = alu_valid && alu_is_load && dep_alu;
    // mem_dep stays high in the data-return cycle: the register file is only
    // readable with the new value one cycle later.
    mem_dep      = load_pending && dep_mem;
    hilo_haz     = muldiv_busy && (decode_reads_hilo || decode_muldiv_start);
    freeze       = load_pending && !mem_data_valid;
    stall        = decode_valid && (load_use || mem_dep || hilo_haz);
    bubble       = stall && !freeze;
    muldiv_start = decode_valid && decode_muldiv_start && !stall && !freeze;
  end

  // Track the single outstanding load; a new load leaving ALU replaces the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_pending <= 1'b0;
      load_rd      <= 5'd0;
    end else if (!freeze && alu_valid && alu_is_load) begin
      load_pending <= 1'b1;
      load_rd      <= alu_rd_index;
    end else if (mem_data_valid) begin
      load_pending <= 1'b0;
    end
  end

  // Mult/div busy timer; runs independently of stall and freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdcnt <= '0;
    end else if (muldiv_start) begin
      mdcnt <= decode_is_div ? DIV_CNT : MULT_CNT;
    end else if (mdcnt != '0) begin
      mdcnt <= mdcnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_interlock.sv
// Bench for pipeline_interlock: directed hazard scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_pipeline_interlock;

  logic       clk = 1'b0;
  logic       rst;
  logic       decode_valid;
  logic [4:0] decode_rs_index;
  logic [4:0] decode_rt_index;
  logic       decode_uses_rs;
  logic       decode_uses_rt;
  logic       decode_reads_hilo;
  logic       decode_muldiv_start;
  logic       decode_is_div;
  logic       alu_valid;
  logic       alu_is_load;
  logic [4:0] alu_rd_index;
  logic       mem_data_valid;
  logic       stall;
  logic       bubble;
  logic       freeze;
  logic       muldiv_start;
  logic       muldiv_busy;

  always #5 clk = ~clk;

  pipeline_interlock #(
    .MULT_LATENCY(4),
    .DIV_LATENCY (32),
    .CNT_WIDTH   (6)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .decode_valid       (decode_valid),
    .decode_rs_index    (decode_rs_index),
    .decode_rt_index    (decode_rt_index),
    .decode_uses_rs     (decode_uses_rs),
    .decode_uses_rt     (decode_uses_rt),
    .decode_reads_hilo  (decode_reads_hilo),
    .decode_muldiv_start(decode_muldiv_start),
    .decode_is_div      (decode_is_div),
    .alu_valid          (alu_valid),
    .alu_is_load        (alu_is_load),
    .alu_rd_index       (alu_rd_index),
    .mem_data_valid     (mem_data_valid),
    .stall              (stall),
    .bubble             (bubble),
    .freeze             (freeze),
    .muldiv_start       (muldiv_start),
    .muldiv_busy        (muldiv_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: outstanding load and the cycle at which mult/div results are ready.
  logic       m_lp = 1'b0;
  logic [4:0] m_lrd = 5'd0;
  int         cyc = 0;
  int         md_ready = 0;
  logic e_freeze, e_stall, e_bubble, e_start, e_busy;

  function automatic logic reads_reg(input logic [4:0] r);
    return (r != 5'd0) &&
           ((decode_uses_rs && decode_rs_index == r) ||
            (decode_uses_rt && decode_rt_index == r));
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Sample mid-cycle and compare every output with the model.
  task automatic cyc_check();
    @(negedge clk);
    e_busy   = (cyc < md_ready);
    e_freeze = m_lp && !mem_data_valid;
    e_stall  = decode_valid &&
               ((alu_valid && alu_is_load && reads_reg(alu_rd_index)) ||
                (m_lp && reads_reg(m_lrd)) ||
                (e_busy && (decode_reads_hilo || decode_muldiv_start)));
    e_bubble = e_stall && !e_freeze;
    e_start  = decode_valid && decode_muldiv_start && !e_stall && !e_freeze;
    chk("model_stall",  stall,        e_stall);
    chk("model_bubble", bubble,       e_bubble);
    chk("model_freeze", freeze,       e_freeze);
    chk("model_start",  muldiv_start, e_start);
    chk("model_busy",   muldiv_busy,  e_busy);
  endtask

  // Advance one clock and update the model with this cycle's inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_lp     = 1'b0;
      m_lrd    = 5'd0;
      md_ready = 0;
    end else begin
      if (!e_freeze && alu_valid && alu_is_load) begin
        m_lp  = 1'b1;
        m_lrd = alu_rd_index;
      end else if (mem_data_valid) begin
        m_lp = 1'b0;
      end
      if (e_start) md_ready = cyc + 1 + (decode_is_div ? 32 : 4);
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; decode_valid = 1'b0; decode_rs_index = 5'd0; decode_rt_index = 5'd0;
    decode_uses_rs = 1'b0; decode_uses_rt = 1'b0; decode_reads_hilo = 1'b0;
    decode_muldiv_start = 1'b0; decode_is_div = 1'b0; alu_valid = 1'b0;
    alu_is_load = 1'b0; alu_rd_index = 5'd0; mem_data_valid = 1'b0;
  endtask

  task automatic alu_load(input logic [4:0] rd);
    alu_valid = 1'b1; alu_is_load = 1'b1; alu_rd_index = rd;
  endtask

  task automatic dec_rs(input logic [4:0] rs);
    decode_valid = 1'b1; decode_uses_rs = 1'b1; decode_rs_index = rs;
  endtask

  initial begin
    // Reset with idle inputs.
    idle(); rst = 1'b1;
    cyc_check();
    chk("rst_stall", stall, 1'b0); chk("rst_freeze", freeze, 1'b0);
    chk("rst_busy", muldiv_busy, 1'b0);
    tick();
    idle();

    // Load-use with data returning the next cycle.
    alu_load(5'd5); dec_rs(5'd5);
    cyc_check(); chk("lu_stall_n", stall, 1'b1); chk("lu_bubble_n", bubble, 1'b1);
    tick();
    alu_valid = 1'b0; alu_is_load = 1'b0; mem_data_valid = 1'b1;
    cyc_check(); chk("lu_stall_n1", stall, 1'b1); chk("lu_freeze_n1", freeze, 1'b0);
    tick();
    mem_data_valid = 1'b0;
    cyc_check(); chk("lu_stall_n2", stall, 1'b0);
    tick();
    idle();

    // Late load data: freeze for three cycles.
    alu_load(5'd7);
    cyc_check(); tick();
    idle(); dec_rs(5'd7);
    for (int i = 0; i < 3; i++) begin
      cyc_check(); chk("late_freeze", freeze, 1'b1); chk("late_bubble", bubble, 1'b0);
      tick();
    end
    mem_data_valid = 1'b1;
    cyc_check(); chk("late_freeze_drop", freeze, 1'b0); chk("late_stall", stall, 1'b1);
    tick();
    idle();

    // Register 0 and unused source fields never match.
    alu_load(5'd0); dec_rs(5'd0);
    cyc_check(); chk("r0_stall", stall, 1'b0); tick();
    idle(); alu_load(5'd5); mem_data_valid = 1'b1;
    decode_valid = 1'b1; decode_uses_rt = 1'b0; decode_rt_index = 5'd5;
    cyc_check(); chk("unused_rt_stall", stall, 1'b0); tick();
    idle(); mem_data_valid = 1'b1; cyc_check(); tick();

    // Back-to-back loads: the newer load replaces the outstanding one.
    idle(); alu_load(5'd3); cyc_check(); tick();
    idle(); alu_load(5'd9); mem_data_valid = 1'b1; cyc_check(); tick();
    idle(); dec_rs(5'd9);
    cyc_check(); chk("b2b_stall_new", stall, 1'b1); chk("b2b_freeze", freeze, 1'b1); tick();
    idle(); dec_rs(5'd3);
    cyc_check(); chk("b2b_stall_old", stall, 1'b0); tick();
    idle(); mem_data_valid = 1'b1; cyc_check(); tick();

    // mult then mflo: stalled for four cycles, issues on the fifth.
    idle(); decode_valid = 1'b1; decode_muldiv_start = 1'b1;
    cyc_check(); chk("mult_start", muldiv_start, 1'b1); tick();
    idle(); decode_valid = 1'b1; decode_reads_hilo = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc_check(); chk("mflo_stall", stall, (k <= 4)); tick();
    end

    // mult, then a div arriving two cycles later waits for the mult.
    idle(); decode_valid = 1'b1; decode_muldiv_start = 1'b1; cyc_check(); tick();
    idle(); decode_valid = 1'b1; decode_reads_hilo = 1'b1; cyc_check(); tick();
    idle(); decode_valid = 1'b1; decode_muldiv_start = 1'b1; decode_is_div = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      cyc_check(); chk("div_start", muldiv_start, (k == 5)); tick();
    end

    // Reset mid-operation with the divider busy and a load outstanding.
    idle();
    for (int k = 0; k < 12; k++) begin cyc_check(); tick(); end
    alu_load(5'd4); cyc_check(); tick();
    idle();
    cyc_check(); chk("pre_rst_busy", muldiv_busy, 1'b1); chk("pre_rst_freeze", freeze, 1'b1);
    rst = 1'b1; tick();
    idle();
    cyc_check(); chk("post_rst_busy", muldiv_busy, 1'b0);
    chk("post_rst_freeze", freeze, 1'b0); chk("post_rst_stall", stall, 1'b0);
    tick();

    // Random traffic with small register indices to provoke matches.
    for (int n = 0; n < 600; n++) begin
      rst                 = ($urandom_range(0, 63) == 0);
      decode_valid        = ($urandom_range(0, 3) != 0);
      decode_rs_index     = 5'($urandom_range(0, 7));
      decode_rt_index     = 5'($urandom_range(0, 7));
      decode_uses_rs      = 1'($urandom_range(0, 1));
      decode_uses_rt      = 1'($urandom_range(0, 1));
      decode_reads_hilo   = ($urandom_range(0, 4) == 0);
      decode_muldiv_start = ($urandom_range(0, 5) == 0);
      decode_is_div       = ($urandom_range(0, 3) == 0);
      alu_valid           = 1'($urandom_range(0, 1));
      alu_is_load         = 1'($urandom_range(0, 1));
      alu_rd_index        = 5'($urandom_range(0, 7));
      mem_data_valid      = 1'($urandom_range(0, 1));
      cyc_check();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
